// File: rtl/sequence_detect_ctrl.sv
// sequence_detect_ctrl: sequenced serial-pattern detector with per-job config, match flags, saturating count
module sequence_detect_ctrl #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   parameter int FRAME_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [3:0]         cfg_len,
   input  logic               cfg_overlap,
   input  logic [FRAME_W-1:0] cfg_frame,
   input  logic               cfg_abort,
   input  logic               data_valid,
   input  logic               data,
   output logic               flag,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   match_cnt
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [3:0] MAX_L = 4'(MAX_LEN);
   state_t             state_q, state_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [3:0]         len_q, len_d;
   logic               ovl_q, ovl_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [MAX_LEN-2:0] hist_q, hist_d;
   logic [3:0]         fill_q, fill_d;
   logic [FRAME_W-1:0] bits_q, bits_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               flag_q, flag_d;
   logic [MAX_LEN-1:0] hist_nx, mask;
   logic [3:0]         fill_nx;
   logic               hit;
   // match evaluation against the history as it will look after the incoming bit
   always_comb begin
      hist_nx = {hist_q, data};
      fill_nx = (fill_q == MAX_L) ? MAX_L : fill_q + 4'd1;
      mask    = ~({MAX_LEN{1'b1}} << len_q);
      hit     = (len_q != 4'd0) && (fill_nx >= len_q) && (((hist_nx ^ pat_q) & mask) == '0);
   end
   // job sequencing: accept config, scan frame bits, pulse done; abort wins over data
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      len_d   = len_q;
      ovl_d   = ovl_q;
      frame_d = frame_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      bits_d  = bits_q;
      cnt_d   = cnt_q;
      flag_d  = 1'b0;
      case (state_q)
         IDLE: if (cfg_valid) begin
            pat_d   = cfg_pattern;
            len_d   = (cfg_len > MAX_L) ? MAX_L : cfg_len;
            ovl_d   = cfg_overlap;
            frame_d = cfg_frame;
            hist_d  = '0;
            fill_d  = '0;
            bits_d  = '0;
            cnt_d   = '0;
            state_d = (cfg_frame == '0) ? DONE : RUN;
         end
         RUN: if (cfg_abort) begin
            state_d = IDLE;
         end else if (data_valid) begin
            hist_d  = hist_nx[MAX_LEN-2:0];
            fill_d  = (hit && !ovl_q) ? 4'd0 : fill_nx;
            bits_d  = bits_q + 1'b1;
            flag_d  = hit;
            cnt_d   = (hit && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
            state_d = (bits_d == frame_q) ? DONE : RUN;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // state and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pat_q   <= '0;
         len_q   <= '0;
         ovl_q   <= 1'b0;
         frame_q <= '0;
         hist_q  <= '0;
         fill_q  <= '0;
         bits_q  <= '0;
         cnt_q   <= '0;
         flag_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         frame_q <= frame_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         bits_q  <= bits_d;
         cnt_q   <= cnt_d;
         flag_q  <= flag_d;
      end
   end
   assign cfg_ready = (state_q == IDLE);
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign flag      = flag_q;
   assign match_cnt = cnt_q;
endmodule

// File: tb/tb_sequence_detect_ctrl.sv
// tb_sequence_detect_ctrl: scoreboard bench with a bit-list reference model for sequence_detect_ctrl
module tb_sequence_detect_ctrl;
   localparam int MAX_LEN = 8;
   localparam int CNT_W   = 2;
   localparam int FRAME_W = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               cfg_valid = 1'b0;
   logic               cfg_ready;
   logic [MAX_LEN-1:0] cfg_pattern = '0;
   logic [3:0]         cfg_len = '0;
   logic               cfg_overlap = 1'b0;
   logic [FRAME_W-1:0] cfg_frame = '0;
   logic               cfg_abort = 1'b0;
   logic               data_valid = 1'b0;
   logic               data = 1'b0;
   logic               flag, busy, done;
   logic [CNT_W-1:0]   match_cnt;
   typedef struct packed {
      logic             is_done;
      logic [CNT_W-1:0] cnt;
   } ev_t;
   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   sequence_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .FRAME_W(FRAME_W)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .cfg_frame(cfg_frame), .cfg_abort(cfg_abort), .data_valid(data_valid), .data(data),
      .flag(flag), .busy(busy), .done(done), .match_cnt(match_cnt)
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask
   function automatic void push(input logic d, input int c);
      exp_q.push_back(ev_t'{is_done: d, cnt: CNT_W'(c)});
   endfunction
   task automatic pop(input logic is_done);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: DUT pulsed with no expected event pending", is_done ? "unexpected done" : "unexpected flag");
      end else begin
         e = exp_q.pop_front();
         check(is_done ? "event kind (done)" : "event kind (flag)", {31'd0, is_done}, {31'd0, e.is_done});
         check(is_done ? "match_cnt at done" : "match_cnt at flag", 32'(match_cnt), 32'(e.cnt));
      end
   endtask
   // monitor: every flag or done pulse consumes the next expected event
   always @(negedge clk) begin
      if (rst) begin
         if (flag) pop(1'b0);
         if (done) pop(1'b1);
      end
   end
   // one job: stream bits are taken MSB-first from stream when use_stream is set
   task automatic run_job(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                          input logic [7:0] frame, input logic [31:0] stream, input bit use_stream,
                          input int gap, input int abort_at, input bit junk);
      int   lm = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
      logic b[$];
      int   st = 0, cm = 0, n = 0, cyc = 0, w;
      logic v, d, m;
      check("ready before job", 32'(cfg_ready), 32'd1);
      cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_frame = frame;
      if (frame == 8'd0) push(1'b1, 0);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      check("busy after handshake", 32'(busy), 32'(frame != 8'd0));
      check("ready after handshake", 32'(cfg_ready), 32'd0);
      while (n < int'(frame)) begin
         if (n == abort_at) begin
            cfg_abort = 1'b1; data_valid = 1'b1; data = 1'($urandom);
            @(posedge clk); #1;
            cfg_abort = 1'b0; data_valid = 1'b0;
            check("ready after abort", 32'(cfg_ready), 32'd1);
            check("busy after abort", 32'(busy), 32'd0);
            check("cnt held after abort", 32'(match_cnt), 32'(cm));
            break;
         end
         v = (gap == 0) ? 1'b1 : (gap == 1) ? ((cyc % 2) == 0) : ($urandom_range(0, 2) != 0);
         cyc++;
         if (use_stream) d = stream[int'(frame) - 1 - n];
         else d = 1'($urandom);
         data_valid = v; data = d;
         if (junk) begin
            cfg_valid = 1'($urandom); cfg_pattern = MAX_LEN'($urandom); cfg_len = 4'($urandom);
            cfg_overlap = 1'($urandom); cfg_frame = FRAME_W'($urandom);
         end
         if (v) begin
            b.push_back(d);
            n++;
            m = 1'b0;
            if (lm > 0 && n - st >= lm) begin
               w = 0;
               for (int k = 0; k < lm; k++) w = (w << 1) | int'(b[n - lm + k]);
               m = (w == (int'(pat) & ((1 << lm) - 1)));
            end
            if (m) begin
               cm = (cm == CNT_MAX) ? CNT_MAX : cm + 1;
               push(1'b0, cm);
               if (!ovl) st = n;
            end
            if (n == int'(frame)) push(1'b1, cm);
         end
         @(posedge clk); #1;
      end
      data_valid = 1'b0; cfg_valid = 1'b0;
      cfg_abort = junk ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
      cfg_abort = 1'b0;
      check("ready after job", 32'(cfg_ready), 32'd1);
      check("busy after job", 32'(busy), 32'd0);
      check("cnt held after job", 32'(match_cnt), 32'(cm));
   endtask
   initial begin
      #1 rst = 1'b0;
      #1;
      check("reset cfg_ready", 32'(cfg_ready), 32'd1);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset flag", 32'(flag), 32'd0);
      check("reset match_cnt", 32'(match_cnt), 32'd0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      run_job(8'h0B, 4'd4, 1'b1, 8'd8, 32'b10110111, 1'b1, 0, -1, 1'b0);
      run_job(8'h0B, 4'd4, 1'b0, 8'd8, 32'b10110111, 1'b1, 0, -1, 1'b0);
      run_job(8'h05, 4'd3, 1'b1, 8'd6, 32'b101010, 1'b1, 1, -1, 1'b0);
      run_job(8'h03, 4'd2, 1'b1, 8'd10, 32'h3FF, 1'b1, 0, -1, 1'b0);
      run_job(8'h0B, 4'd4, 1'b1, 8'd8, 32'b10110111, 1'b1, 0, 3, 1'b0);
      run_job(8'h0B, 4'd4, 1'b1, 8'd8, 32'b10110111, 1'b1, 0, -1, 1'b1);
      run_job(8'h0B, 4'd4, 1'b1, 8'd0, 32'd0, 1'b1, 0, -1, 1'b0);
      run_job(8'h00, 4'd0, 1'b1, 8'd4, 32'hF, 1'b1, 0, -1, 1'b0);
      run_job(8'hA5, 4'd15, 1'b1, 8'd12, 32'b101001011010, 1'b1, 0, -1, 1'b0);
      for (int j = 0; j < 60; j++) begin
         logic [7:0] fr;
         logic [3:0] ln;
         fr = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 24));
         ln = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
         run_job(8'($urandom), ln, 1'($urandom), fr, 32'd0, 1'b0, $urandom_range(0, 2),
                 ($urandom_range(0, 5) == 0) ? $urandom_range(0, 24) : -1, 1'b1);
      end
      check("ready before reset job", 32'(cfg_ready), 32'd1);
      cfg_valid = 1'b1; cfg_pattern = 8'h03; cfg_len = 4'd2; cfg_overlap = 1'b1; cfg_frame = 8'd8;
      @(posedge clk); #1;
      cfg_valid = 1'b0; data_valid = 1'b1; data = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i >= 1) push(1'b0, i);
         @(posedge clk); #1;
      end
      data_valid = 1'b0;
      @(negedge clk); #1;
      check("busy before reset", 32'(busy), 32'd1);
      check("flag before reset", 32'(flag), 32'd1);
      check("cnt before reset", 32'(match_cnt), 32'd2);
      rst = 1'b0;
      #1;
      check("async reset flag", 32'(flag), 32'd0);
      check("async reset busy", 32'(busy), 32'd0);
      check("async reset done", 32'(done), 32'd0);
      check("async reset match_cnt", 32'(match_cnt), 32'd0);
      check("async reset cfg_ready", 32'(cfg_ready), 32'd1);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      run_job(8'h0B, 4'd4, 1'b1, 8'd8, 32'b10110111, 1'b1, 0, -1, 1'b0);
      repeat (2) @(posedge clk);
      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
